powlib_dpram_arb: RTL
=====================

# powlib_dpram_arb

Shares one single-clock dual-port RAM among N requesters. Each requester issues write or read transactions over a valid/ready handshake. A round-robin arbiter (or, optionally, a fixed-priority arbiter) grants at most one transaction per cycle. Read data returns one cycle later, tagged with the requester id. The block sits between several producer/consumer engines and a shared `powlib_dpram` instance (`EASYNC=0`, `ERRD=1`), which it contains internally.

## Interface
Parameters:
- `N`, 4: number of requesters, at least 1.
- `W`, 32: data width.
- `D`, 128: RAM depth.
- `WIDX`, `powlib_clogb2(D)`: index width.
- `WID`, `powlib_clogb2(N)`: requester-id width; forced to a minimum of 1.
- `EFP`, 0: 0 selects round-robin, 1 selects fixed priority (lowest index wins).
- `INIT`, 0: `[W*D-1:0]` initial RAM contents, passed to the RAM.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `hold`  in  1  while high, no grants are issued.
- `reqvld`  in  N  per-requester transaction valid.
- `reqrdy`  out  N  per-requester grant; one-hot or zero.
- `reqwr`  in  N  per requester: 1 = write, 0 = read.
- `reqidx`  in  N*WIDX  packed indexes; requester i uses `[i*WIDX +: WIDX]`.
- `reqdata`  in  N*W  packed write data; requester i uses `[i*W +: W]`.
- `rspvld`  out  1  read-response valid, one-cycle pulse.
- `rspdata`  out  W  read data.
- `rspid`  out  WID  id of the requester that issued the read.

## Operation
- A transaction completes on a clock edge where `reqvld[i] && reqrdy[i]`.
- Requesters hold `reqvld`, `reqwr`, `reqidx` and `reqdata` stable until that edge.
- `reqrdy` is combinational from `reqvld`, `hold`, the priority pointer `ptr` and `rst`.
  - It is all-zero when `hold==1` or `rst==0`.
  - Otherwise it is set for exactly one asserted `reqvld` bit.
  - A requester may not make `reqvld` depend on `reqrdy`.
- Round-robin (`EFP=0`):
  - The search starts at `(ptr+1) mod N` and wraps; the first asserted `reqvld` wins.
  - On each completed transaction, `ptr` is set to the granted index. Otherwise `ptr` is unchanged.
  - Reset value of `ptr` is N-1, so requester 0 has the highest priority after reset.
- Fixed priority (`EFP=1`): the lowest asserted index wins and `ptr` is unused.
- Granted write: the RAM write enable is asserted with `reqidx[i]` and `reqdata[i]`. `mem[idx]` is updated at that edge.
- Granted read:
  - `reqidx[i]` drives the RAM read index and the registered RAM output captures `mem[idx]` at that edge.
  - At the same edge, a registered flag and tag capture 1 and i.
- `rspvld` and `rspid` are the registered flag and tag. `rspdata` is the registered RAM output.
- Responses have no backpressure; consumers must always accept `rspvld`.
- Read ordering:
  - Write of addr A at cycle t, then a read of A granted at cycle t+1 or later, returns the new data.
  - Only one transaction is granted per cycle, so a same-cycle read/write collision cannot occur.
- Index wrap: `reqidx` values at or above D are out of range. Writes to them are ignored and reads return X. The bench must not issue them.
- With N=1 there is no arbitration: `reqrdy[0] = reqvld[0] && !hold && rst`.

## Timing
- Reset (`rst` low, asynchronous) has immediate effect:
  - `rspvld` = 0, `rspid` = 0, `ptr` = N-1, `reqrdy` = 0.
  - `rspdata` and the RAM contents are not reset.
- Leaving reset: the first grant is possible in the first cycle with `rst` high.
- Reset during a read: a read handshaken in the cycle before `rst` falls produces no `rspvld`; the pending response is dropped.
- Grant latency is 0 cycles: `reqrdy` is asserted in the same cycle as `reqvld` when the requester wins.
- Read latency: a handshake at edge k gives `rspvld`=1 with valid data in the cycle after edge k.
- Throughput: one transaction per cycle. Back-to-back reads give consecutive `rspvld` pulses, each with its own `rspid`.
- Fairness: with all N requesters continuously valid under round-robin, each is granted once every N cycles.
- `hold` asserted: it takes effect in the same cycle. `ptr` is frozen and in-flight responses still complete.

## Test plan
- Reset and idle: `rst` low, then high, with no `reqvld` → `reqrdy`=0, `rspvld`=0 and `rspid`=0 throughout.
- Write then read, N=4: requester 2 writes 0xDEADBEEF to idx 5, then reads idx 5 in the next cycle → `rspvld` pulses 1 cycle after the read grant with `rspdata`=0xDEADBEEF and `rspid`=2.
- Round-robin fairness: all 4 requesters hold valid reads for 8 cycles → grant order 0,1,2,3,0,1,2,3 and 8 consecutive `rspvld` pulses with ids in the same order.
- Fixed priority (`EFP=1`): requesters 1 and 3 held valid → requester 1 is granted every cycle and requester 3 is never granted until requester 1 drops.
- `hold`: all requesters valid, `hold` high for 3 cycles → `reqrdy`=0 for those cycles. After release, the grant resumes at the index following the last grant before `hold`.
- Async reset mid-read: a read is granted, then `rst` is pulled low before the next edge → `rspvld` stays 0 and the next grant goes to requester 0 (`ptr`=3).

Source files
------------

// File: rtl/powlib_dpram_arb.sv
// Shares one single-clock dual-port RAM among N requesters. Round-robin or
// fixed-priority grant, one transaction per cycle, id-tagged read responses.
module powlib_dpram_arb #(
    parameter int             N    = 4,
    parameter int             W    = 32,
    parameter int             D    = 128,
    parameter int             WIDX = (D > 1) ? $clog2(D) : 1,
    parameter int             WID  = (N > 1) ? $clog2(N) : 1,
    parameter int             EFP  = 0,
    parameter logic [W*D-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [N-1:0]      reqvld,
    output logic [N-1:0]      reqrdy,
    input  logic [N-1:0]      reqwr,
    input  logic [N*WIDX-1:0] reqidx,
    input  logic [N*W-1:0]    reqdata,
    output logic              rspvld,
    output logic [W-1:0]      rspdata,
    output logic [WID-1:0]    rspid
);

    typedef logic [W-1:0] mem_t [D];

    function automatic mem_t init_mem();
        mem_t m;
        for (int d = 0; d < D; d++) begin
            m[d] = INIT[d*W +: W];
        end
        return m;
    endfunction

    logic [WID-1:0]  ptr_r;
    logic            rspvld_r;
    logic [WID-1:0]  rspid_r;
    logic [W-1:0]    rdata_r;
    mem_t            mem_r = init_mem();

    logic            hi_found_s;
    logic [WID-1:0]  hi_id_s;
    logic [WID-1:0]  lo_id_s;
    logic            any_s;
    logic [WID-1:0]  win_id_s;
    logic [N-1:0]    grant_s;
    logic            sel_wr_s;
    logic [WIDX-1:0] sel_idx_s;
    logic [W-1:0]    sel_data_s;
    logic            wr_en_s;
    logic            rd_en_s;
    logic            in_range_s;

    // Winner search: lowest valid index above ptr, else lowest valid overall (wrap).
    always_comb begin
        hi_found_s = 1'b0;
        hi_id_s    = '0;
        lo_id_s    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            lo_id_s    = reqvld[i] ? WID'(i) : lo_id_s;
            hi_found_s = (reqvld[i] && (EFP == 0) && (WID'(i) > ptr_r)) ? 1'b1 : hi_found_s;
            hi_id_s    = (reqvld[i] && (EFP == 0) && (WID'(i) > ptr_r)) ? WID'(i) : hi_id_s;
        end
        any_s    = (|reqvld) && rst && !hold;
        win_id_s = hi_found_s ? hi_id_s : lo_id_s;
    end

    // One-hot grant and the granted requester's command fields (OR-mux on the grant).
    always_comb begin
        grant_s    = '0;
        sel_wr_s   = 1'b0;
        sel_idx_s  = '0;
        sel_data_s = '0;
        for (int i = 0; i < N; i++) begin
            grant_s[i] = any_s && (win_id_s == WID'(i));
            sel_wr_s   = sel_wr_s | (grant_s[i] & reqwr[i]);
            sel_idx_s  = sel_idx_s | ({WIDX{grant_s[i]}} & reqidx[i*WIDX +: WIDX]);
            sel_data_s = sel_data_s | ({W{grant_s[i]}} & reqdata[i*W +: W]);
        end
        wr_en_s    = any_s & sel_wr_s;
        rd_en_s    = any_s & ~sel_wr_s;
        in_range_s = (int'(sel_idx_s) < D);
    end

    assign reqrdy  = grant_s;
    assign rspvld  = rspvld_r;
    assign rspid   = rspid_r;
    assign rspdata = rdata_r;

    // RAM write port; out-of-range indexes are dropped.
    always_ff @(posedge clk) begin
        if (wr_en_s && in_range_s) begin
            mem_r[sel_idx_s] <= sel_data_s;
        end
    end

    // Registered RAM read data, captured only on a granted read.
    always_ff @(posedge clk) begin
        if (rd_en_s) begin
            rdata_r <= mem_r[sel_idx_s];
        end
    end

    // Priority pointer and response flag/tag; reset drops any pending response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r    <= WID'(N - 1);
            rspvld_r <= 1'b0;
            rspid_r  <= '0;
        end else begin
            rspvld_r <= rd_en_s;
            if (rd_en_s) begin
                rspid_r <= win_id_s;
            end
            if (any_s && (EFP == 0)) begin
                ptr_r <= win_id_s;
            end
        end
    end

endmodule
